// File: rtl/hit_judge_if.sv
// Hit-judge bus: timing strobes and button in, judgement and combo out.
// The master side drives the stimulus. The judge itself is the slave.
interface hit_judge_if;
   logic       tick;
   logic       note_arrive;
   logic       btn;
   logic [1:0] current_state;
   logic [1:0] judge;
   logic       miss;
   logic [7:0] combo;
   logic [7:0] max_combo;

   modport master (
      output tick, note_arrive, btn, current_state,
      input  judge, miss, combo, max_combo
   );

   modport slave (
      input  tick, note_arrive, btn, current_state,
      output judge, miss, combo, max_combo
   );
endinterface

// File: rtl/hit_judge.sv
// Rhythm-game timing judge: opens a tick-counted window per note, classifies the
// press as early/perfect/late or miss, and keeps a saturating combo and its maximum.
module hit_judge #(
   parameter int unsigned EARLY_T    = 3,
   parameter int unsigned PERFECT_T  = 4,
   parameter int unsigned WINDOW_T   = 12,
   parameter logic [1:0]  PLAY_STATE = 2'b01
) (
   input  logic     clk,
   input  logic     reset,
   hit_judge_if.slave bus
);

   typedef enum logic {IDLE, OPEN} state_t;

   localparam logic [8:0] EARLY_END   = 9'(EARLY_T);
   localparam logic [8:0] PERFECT_END = 9'(EARLY_T + PERFECT_T);
   localparam logic [7:0] LAST_E      = 8'(WINDOW_T - 1);

   state_t     state_q, state_d;
   logic [7:0] e_q, e_d;
   logic       btn_prev_q, btn_prev_d;
   logic       play_prev_q, play_prev_d;
   logic [1:0] judge_q, judge_d;
   logic       miss_q, miss_d;
   logic [7:0] combo_q, combo_d;
   logic [7:0] max_combo_q, max_combo_d;

   logic       play;
   logic       press;
   logic       hit;
   logic [7:0] combo_base;
   logic [7:0] max_base;

   function automatic logic [1:0] zone_of(input logic [7:0] e);
      if ({1'b0, e} < EARLY_END)        return 2'b01;
      else if ({1'b0, e} < PERFECT_END) return 2'b11;
      else                              return 2'b10;
   endfunction

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      play        = (bus.current_state == PLAY_STATE);
      press       = bus.btn & ~btn_prev_q;
      btn_prev_d  = bus.btn;
      play_prev_d = play;
      state_d     = state_q;
      e_d         = e_q;
      judge_d     = 2'b00;
      miss_d      = 1'b0;
      combo_d     = combo_q;
      max_combo_d = max_combo_q;
      hit         = 1'b0;
      // Entering play starts a fresh run: the first play cycle judges against cleared counts.
      combo_base  = play_prev_q ? combo_q     : 8'd0;
      max_base    = play_prev_q ? max_combo_q : 8'd0;

      if (play) begin
         combo_d     = combo_base;
         max_combo_d = max_base;
         case (state_q)
            IDLE: begin
               if (bus.note_arrive) begin
                  e_d = 8'd0;
                  if (press) begin
                     hit     = 1'b1;
                     judge_d = zone_of(8'd0);
                  end else begin
                     state_d = OPEN;
                  end
               end
            end
            OPEN: begin
               // A press always settles the old note before any overrun or expiry.
               if (press) begin
                  hit     = 1'b1;
                  judge_d = zone_of(e_q);
                  e_d     = 8'd0;
                  state_d = bus.note_arrive ? OPEN : IDLE;
               end else if (bus.note_arrive) begin
                  miss_d  = 1'b1;
                  e_d     = 8'd0;
                  state_d = OPEN;
               end else if (bus.tick) begin
                  if (e_q == LAST_E) begin
                     miss_d  = 1'b1;
                     e_d     = 8'd0;
                     state_d = IDLE;
                  end else begin
                     e_d = e_q + 8'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (hit) combo_d = (combo_base == 8'hFF) ? 8'hFF : combo_base + 8'd1;
         if (miss_d) combo_d = 8'd0;
         if (combo_d > max_base) max_combo_d = combo_d;
      end else begin
         state_d = IDLE;
         e_d     = 8'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values computed before this edge regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         e_q         <= 8'd0;
         btn_prev_q  <= 1'b0;
         play_prev_q <= 1'b0;
         judge_q     <= 2'b00;
         miss_q      <= 1'b0;
         combo_q     <= 8'd0;
         max_combo_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         e_q         <= e_d;
         btn_prev_q  <= btn_prev_d;
         play_prev_q <= play_prev_d;
         judge_q     <= judge_d;
         miss_q      <= miss_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
      end
   end

   assign bus.judge     = judge_q;
   assign bus.miss      = miss_q;
   assign bus.combo     = combo_q;
   assign bus.max_combo = max_combo_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: zones, expiry, overrun, saturation, gating, reset.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_hit_judge;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   exp_combo = 0;
   int   exp_max   = 0;

   always #5 clk = ~clk;

   hit_judge_if bus ();

   hit_judge dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic na, input logic tk, input logic b);
      @(negedge clk);
      bus.note_arrive = na;
      bus.tick        = tk;
      bus.btn         = b;
      @(posedge clk);
      #1;
   endtask

   task automatic model_hit();
      exp_combo = (exp_combo == 255) ? 255 : exp_combo + 1;
      if (exp_combo > exp_max) exp_max = exp_combo;
   endtask

   task automatic check_counts(input string tag);
      check({tag, ".combo"}, int'(bus.combo), exp_combo);
      check({tag, ".max"}, int'(bus.max_combo), exp_max);
   endtask

   // Open a window, advance n ticks, press, expect judgement j for exactly one cycle.
   task automatic hit_at(input int n, input int j, input string tag);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (n) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      model_hit();
      check({tag, ".judge"}, int'(bus.judge), j);
      check_counts(tag);
      cyc(1'b0, 1'b0, 1'b0);
      check({tag, ".judge_clr"}, int'(bus.judge), 0);
   endtask

   task automatic reenter_play(input string tag);
      bus.current_state = 2'b00;
      cyc(1'b0, 1'b0, 1'b0);
      bus.current_state = 2'b01;
      cyc(1'b0, 1'b0, 1'b0);
      exp_combo = 0;
      exp_max   = 0;
      check_counts(tag);
   endtask

   initial begin
      reset             = 1'b0;
      bus.tick          = 1'b0;
      bus.note_arrive   = 1'b0;
      bus.btn           = 1'b0;
      bus.current_state = 2'b00;
      #12;
      check("rst.judge", int'(bus.judge), 0);
      check("rst.miss", int'(bus.miss), 0);
      check_counts("rst");
      @(negedge clk);
      reset = 1'b1;
      bus.current_state = 2'b01;
      cyc(1'b0, 1'b0, 1'b0);

      // Perfect hit after 4 ticks.
      hit_at(4, 3, "perfect");

      // Zone boundaries over six notes from a cleared combo.
      reenter_play("reenter1");
      hit_at(0,  1, "zone_e0");
      hit_at(2,  1, "zone_e2");
      hit_at(3,  3, "zone_e3");
      hit_at(6,  3, "zone_e6");
      hit_at(7,  2, "zone_e7");
      hit_at(11, 2, "zone_e11");
      check("zones.combo6", int'(bus.combo), 6);

      // Build combo 5, then let a window expire.
      reenter_play("reenter2");
      repeat (5) hit_at(0, 1, "build");
      cyc(1'b1, 1'b0, 1'b0);
      repeat (11) cyc(1'b0, 1'b1, 1'b0);
      check("expire.early_miss", int'(bus.miss), 0);
      cyc(1'b0, 1'b1, 1'b0);
      exp_combo = 0;
      check("expire.miss", int'(bus.miss), 1);
      check("expire.judge", int'(bus.judge), 0);
      check_counts("expire");
      check("expire.max5", int'(bus.max_combo), 5);
      cyc(1'b0, 1'b0, 1'b0);
      check("expire.miss_clr", int'(bus.miss), 0);

      // Overrun: second note while open, new window restarts at e=0.
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("overrun.miss", int'(bus.miss), 1);
      check_counts("overrun");
      cyc(1'b0, 1'b1, 1'b0);
      check("overrun.miss_clr", int'(bus.miss), 0);
      cyc(1'b0, 1'b0, 1'b1);
      model_hit();
      check("overrun.judge_e1", int'(bus.judge), 1);
      check_counts("overrun_hit");
      cyc(1'b0, 1'b0, 1'b0);

      // Press coinciding with the expiring tick wins as late.
      cyc(1'b1, 1'b0, 1'b0);
      repeat (11) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      model_hit();
      check("edge.judge", int'(bus.judge), 2);
      check("edge.miss", int'(bus.miss), 0);
      check_counts("edge");
      cyc(1'b0, 1'b0, 1'b0);
      check("edge.miss_after", int'(bus.miss), 0);

      // Press together with a new note while open: old note judged, new window opens.
      cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      model_hit();
      check("renote.judge", int'(bus.judge), 3);
      check("renote.miss", int'(bus.miss), 0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      model_hit();
      check("renote.new_judge", int'(bus.judge), 1);
      check_counts("renote");
      cyc(1'b0, 1'b0, 1'b0);

      // Held button is a single press.
      cyc(1'b1, 1'b0, 1'b1);
      model_hit();
      check("hold.first", int'(bus.judge), 1);
      cyc(1'b1, 1'b0, 1'b1);
      check("hold.no_repress", int'(bus.judge), 0);
      check_counts("hold");
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      model_hit();
      check("hold.repress", int'(bus.judge), 1);
      cyc(1'b0, 1'b0, 1'b0);

      // Saturation over 260 hits.
      for (int i = 0; i < 260; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         model_hit();
         check("sat.combo", int'(bus.combo), exp_combo);
         cyc(1'b0, 1'b0, 1'b0);
      end
      check("sat.255", int'(bus.combo), 255);
      check("sat.max255", int'(bus.max_combo), 255);

      // Gating: outside play, presses are ignored and counts held.
      bus.current_state = 2'b10;
      cyc(1'b1, 1'b0, 1'b1);
      check("gate.judge", int'(bus.judge), 0);
      check_counts("gate");
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      check("gate.judge2", int'(bus.judge), 0);
      check("gate.miss", int'(bus.miss), 0);
      cyc(1'b0, 1'b0, 1'b0);
      bus.current_state = 2'b01;
      cyc(1'b0, 1'b0, 1'b0);
      exp_combo = 0;
      exp_max   = 0;
      check_counts("regate");

      // Reset mid-window at e=5 with a nonzero combo.
      repeat (3) hit_at(0, 1, "pre_rst");
      cyc(1'b1, 1'b0, 1'b0);
      repeat (5) cyc(1'b0, 1'b1, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      exp_combo = 0;
      exp_max   = 0;
      check("arst.judge", int'(bus.judge), 0);
      check("arst.miss", int'(bus.miss), 0);
      check_counts("arst");
      @(negedge clk);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      check("arst.press_judge", int'(bus.judge), 0);
      check("arst.press_miss", int'(bus.miss), 0);
      check_counts("arst_press");
      cyc(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
